// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch push-button front end.
// The state enum and the button indices are shared by the controller and its bench.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        SW_IDLE,
        SW_RUN,
        SW_PAUSE
    } sw_state_e;

    localparam int BTN_RESET = 0;
    localparam int BTN_START = 1;
    localparam int BTN_STOP  = 2;
    localparam int NUM_BTN   = 3;

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: a two-flop synchronizer, a debounce counter and a rising-edge detect.
// The press output pulses for one cycle, in the cycle after the debounced level goes from 0 to 1.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DB_W-1:0] CNT_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic            stable;
    logic            stable_d;
    logic [DB_W-1:0] cnt;

    // The counter increment that would bring it to DEBOUNCE_CYCLES commits the new level instead.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            s1       <= raw;
            s2       <= s1;
            stable_d <= stable;
            if (s2 != stable) begin
                if (cnt == CNT_LAST) begin
                    stable <= s2;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end else begin
                cnt <= '0;
            end
        end
    end

    assign level = stable;
    assign press = stable & ~stable_d;

endmodule

// File: rtl/stopwatch_btn_ctrl.sv
// Turns three raw buttons into clean reset/start/stop commands for the stopwatch.
// It tracks the stopwatch run state and suppresses presses that are redundant or that lose arbitration.
module stopwatch_btn_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_reset_raw,
    input  logic btn_start_raw,
    input  logic btn_stop_raw,
    output logic sw_reset,
    output logic sw_start,
    output logic sw_stop,
    output logic running,
    output logic dropped
);

    logic [NUM_BTN-1:0] raw_vec;
    logic [NUM_BTN-1:0] press_vec;
    // The arbiter acts only on press events, so the debounced levels go unused.
    logic [NUM_BTN-1:0] level_unused;

    assign raw_vec[BTN_RESET] = btn_reset_raw;
    assign raw_vec[BTN_START] = btn_start_raw;
    assign raw_vec[BTN_STOP]  = btn_stop_raw;

    for (genvar i = BTN_RESET; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_btn (
            .clk  (clk),
            .reset(reset),
            .raw  (raw_vec[i]),
            .level(level_unused[i]),
            .press(press_vec[i])
        );
    end

    sw_state_e state;
    sw_state_e next_state;
    logic      next_reset;
    logic      next_start;
    logic      next_stop;
    logic      next_drop;

    // A reset press beats everything; start and stop are weighed against the current state.
    always_comb begin
        next_state = state;
        next_reset = 1'b0;
        next_start = 1'b0;
        next_stop  = 1'b0;
        next_drop  = 1'b0;
        if (press_vec[BTN_RESET]) begin
            next_state = SW_IDLE;
            next_reset = 1'b1;
            next_drop  = press_vec[BTN_START] | press_vec[BTN_STOP];
        end else begin
            case (state)
                SW_RUN: begin
                    if (press_vec[BTN_STOP]) begin
                        next_state = SW_PAUSE;
                        next_stop  = 1'b1;
                        next_drop  = press_vec[BTN_START];
                    end else if (press_vec[BTN_START]) begin
                        next_drop = 1'b1;
                    end
                end
                SW_IDLE, SW_PAUSE: begin
                    if (press_vec[BTN_START]) begin
                        next_state = SW_RUN;
                        next_start = 1'b1;
                        next_drop  = press_vec[BTN_STOP];
                    end else if (press_vec[BTN_STOP]) begin
                        next_drop = 1'b1;
                    end
                end
                default: next_state = SW_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= SW_IDLE;
            sw_reset <= 1'b0;
            sw_start <= 1'b0;
            sw_stop  <= 1'b0;
            running  <= 1'b0;
            dropped  <= 1'b0;
        end else begin
            state    <= next_state;
            sw_reset <= next_reset;
            sw_start <= next_start;
            sw_stop  <= next_stop;
            running  <= (next_state == SW_RUN);
            dropped  <= next_drop;
        end
    end

endmodule

// File: tb/tb_stopwatch_btn_ctrl.sv
// Scoreboard bench for stopwatch_btn_ctrl: each press pushes its expected pulse, and a monitor pops and compares.
// A small state model of the controller predicts which command or drop each press should give.
module tb_stopwatch_btn_ctrl;
    import stopwatch_pkg::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic btn_reset_raw = 1'b0;
    logic btn_start_raw = 1'b0;
    logic btn_stop_raw = 1'b0;
    logic sw_reset;
    logic sw_start;
    logic sw_stop;
    logic running;
    logic dropped;

    stopwatch_btn_ctrl #(
        .DEBOUNCE_CYCLES(N)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .btn_reset_raw(btn_reset_raw),
        .btn_start_raw(btn_start_raw),
        .btn_stop_raw (btn_stop_raw),
        .sw_reset     (sw_reset),
        .sw_start     (sw_start),
        .sw_stop      (sw_stop),
        .running      (running),
        .dropped      (dropped)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt++;

    typedef struct {
        int   cycle;
        logic rst;
        logic start;
        logic stop;
        logic drop;
        logic run;
    } exp_t;

    exp_t      exp_q[$];
    exp_t      mon_e;
    sw_state_e model_state = SW_IDLE;
    int        checks = 0;
    int        fails = 0;
    bit        mon_en = 1'b0;

    // Any pulse must match the oldest expectation, both in its value and in the edge it appears on.
    always @(negedge clk) begin
        if (mon_en) begin
            if (sw_reset === 1'b1 || sw_start === 1'b1 || sw_stop === 1'b1 || dropped === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("[TB] FAIL unexpected_pulse edge=%0d got rst/start/stop/drop=%b%b%b%b required none",
                             edge_cnt, sw_reset, sw_start, sw_stop, dropped);
                end else begin
                    mon_e = exp_q.pop_front();
                    if ({sw_reset, sw_start, sw_stop, dropped, running} !==
                            {mon_e.rst, mon_e.start, mon_e.stop, mon_e.drop, mon_e.run} ||
                            edge_cnt != mon_e.cycle) begin
                        fails++;
                        $display("[TB] FAIL pulse_check got rst/start/stop/drop/run=%b%b%b%b%b at edge %0d, required %b%b%b%b%b at edge %0d",
                                 sw_reset, sw_start, sw_stop, dropped, running, edge_cnt,
                                 mon_e.rst, mon_e.start, mon_e.stop, mon_e.drop, mon_e.run, mon_e.cycle);
                    end
                end
            end else if (exp_q.size() > 0 && edge_cnt > exp_q[0].cycle) begin
                checks++;
                fails++;
                mon_e = exp_q.pop_front();
                $display("[TB] FAIL missed_pulse got nothing at edge %0d, required rst/start/stop/drop=%b%b%b%b",
                         mon_e.cycle, mon_e.rst, mon_e.start, mon_e.stop, mon_e.drop);
            end
        end
    end

    // Press the buttons in mask together for hold cycles, predicting the controller's response.
    task automatic apply_press(input logic [NUM_BTN-1:0] mask, input int hold);
        exp_t e;
        int   k;
        logic prev_run;
        @(negedge clk);
        if (mask[BTN_RESET]) btn_reset_raw = 1'b1;
        if (mask[BTN_START]) btn_start_raw = 1'b1;
        if (mask[BTN_STOP])  btn_stop_raw = 1'b1;
        k = edge_cnt + 1;
        prev_run = (model_state == SW_RUN);
        e.cycle = k + N + 2;
        e.rst = 1'b0;
        e.start = 1'b0;
        e.stop = 1'b0;
        e.drop = 1'b0;
        if (mask[BTN_RESET]) begin
            e.rst = 1'b1;
            e.drop = mask[BTN_START] | mask[BTN_STOP];
            model_state = SW_IDLE;
        end else if (model_state == SW_RUN) begin
            if (mask[BTN_STOP]) begin
                e.stop = 1'b1;
                e.drop = mask[BTN_START];
                model_state = SW_PAUSE;
            end else if (mask[BTN_START]) begin
                e.drop = 1'b1;
            end
        end else begin
            if (mask[BTN_START]) begin
                e.start = 1'b1;
                e.drop = mask[BTN_STOP];
                model_state = SW_RUN;
            end else if (mask[BTN_STOP]) begin
                e.drop = 1'b1;
            end
        end
        e.run = (model_state == SW_RUN);
        if (e.rst || e.start || e.stop || e.drop) exp_q.push_back(e);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            if (edge_cnt == k + N + 1) begin
                checks++;
                if (running !== prev_run) begin
                    fails++;
                    $display("[TB] FAIL running_before_pulse edge=%0d got %b required %b", edge_cnt, running, prev_run);
                end
            end
        end
        if (mask[BTN_RESET]) btn_reset_raw = 1'b0;
        if (mask[BTN_START]) btn_start_raw = 1'b0;
        if (mask[BTN_STOP])  btn_stop_raw = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("[TB] FAIL %s_drain got %0d pending events required 0", name, exp_q.size());
            exp_q.delete();
        end
        checks++;
        if (running !== (model_state == SW_RUN)) begin
            fails++;
            $display("[TB] FAIL %s_running got %b required %b", name, running, model_state == SW_RUN);
        end
    endtask

    task automatic do_sync_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_state = SW_IDLE;
        checks++;
        if (running !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sync_reset_running got %b required 0", running);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            checks++;
            if ({sw_reset, sw_start, sw_stop, running, dropped} !== 5'b0) begin
                fails++;
                $display("[TB] FAIL reset_idle cycle=%0d got rst/start/stop/run/drop=%b%b%b%b%b required 00000",
                         i, sw_reset, sw_start, sw_stop, running, dropped);
            end
        end
        mon_en = 1'b1;
    endtask

    task automatic test_start_latency();
        apply_press(NUM_BTN'(1 << BTN_START), 8);
        wait_drain("start_latency");
    endtask

    task automatic test_glitch();
        @(negedge clk);
        btn_stop_raw = 1'b1;
        repeat (3) @(negedge clk);
        btn_stop_raw = 1'b0;
        repeat (15) @(negedge clk);
        wait_drain("glitch");
    endtask

    task automatic test_full_sequence();
        do_sync_reset();
        apply_press(NUM_BTN'(1 << BTN_START), 8);
        repeat (10) @(negedge clk);
        apply_press(NUM_BTN'(1 << BTN_STOP), 8);
        repeat (10) @(negedge clk);
        apply_press(NUM_BTN'(1 << BTN_START), 8);
        repeat (10) @(negedge clk);
        apply_press(NUM_BTN'(1 << BTN_RESET), 8);
        wait_drain("full_sequence");
    endtask

    task automatic test_redundancy();
        apply_press(NUM_BTN'(1 << BTN_STOP), 8);
        repeat (10) @(negedge clk);
        apply_press(NUM_BTN'(1 << BTN_START), 8);
        repeat (10) @(negedge clk);
        apply_press(NUM_BTN'(1 << BTN_START), 8);
        wait_drain("redundancy");
    endtask

    task automatic test_simultaneous();
        apply_press(NUM_BTN'(1 << BTN_STOP), 8);
        repeat (10) @(negedge clk);
        apply_press(NUM_BTN'((1 << BTN_START) | (1 << BTN_STOP)), 8);
        repeat (10) @(negedge clk);
        apply_press(NUM_BTN'((1 << BTN_RESET) | (1 << BTN_STOP)), 8);
        wait_drain("simultaneous");
    endtask

    task automatic test_reset_mid_debounce();
        apply_press(NUM_BTN'(1 << BTN_START), 8);
        repeat (10) @(negedge clk);
        wait_drain("mid_debounce_setup");
        @(negedge clk);
        btn_stop_raw = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        btn_stop_raw = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        model_state = SW_IDLE;
        repeat (20) @(negedge clk);
        wait_drain("mid_debounce");
    endtask

    initial begin
        test_reset();
        test_start_latency();
        test_glitch();
        test_full_sequence();
        test_redundancy();
        test_simultaneous();
        test_reset_mid_debounce();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
